// File: rtl/seq_detector_moore_param.sv
// seq_detector_moore_param
//   Moore serial sequence detector for a compile-time pattern. It supports
//   overlapping or non-overlapping matching, a sample-enable qualifier, and a
//   saturating match counter with a sticky saturation flag.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  pattern to match; the MSB is the first bit received
//   OVERLAP  1: a completed match may seed the next one, 0: restart after a match
//   CNT_W    match counter width (1..32)
//
// Ports
//   clk          clock; all logic is on posedge
//   rst          synchronous active-low reset
//   inp          serial data bit, sampled when en=1
//   en           sample qualifier; en=0 holds the FSM, out and the counter
//   clr_cnt      synchronous clear of match_count and count_sat (ignores en)
//   out          1 while the FSM is in DETECT
//   match_count  saturating count of DETECT entries
//   count_sat    sticky flag, set when match_count reaches its maximum
module seq_detector_moore_param #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int unsigned SW = $clog2(PAT_W + 1);

  // Sk means the first k pattern bits are matched; StDetect is S(PAT_W).
  // Intermediate states are reached by casting the transition table entries.
  typedef enum logic [SW-1:0] {
    StS0     = SW'(0),
    StDetect = SW'(PAT_W)
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntPre = CntMax - CNT_W'(1);

  // Next state from state k on bit b: length of the longest pattern prefix that
  // is a suffix of (first k pattern bits, b). For k = PAT_W the whole pattern
  // precedes b, which yields the overlapping-match continuation. Lengths are
  // tried in ascending order so the longest match is the one kept.
  function automatic logic [SW-1:0] next_of(input int k, input logic b);
    int               str_len;
    int               idx;
    logic             ok;
    logic             sbit;
    logic             pbit;
    logic [PAT_W-1:0] tmp;
    logic [SW-1:0]    res;
    str_len = k + 1;
    res     = '0;
    for (int n = 1; n <= int'(PAT_W); n++) begin
      if (n <= str_len) begin
        ok = 1'b1;
        for (int j = 0; j < int'(PAT_W); j++) begin
          if (j < n) begin
            idx = str_len - n + j;
            if (idx < k) begin
              tmp  = PATTERN >> (int'(PAT_W) - 1 - idx);
              sbit = tmp[0];
            end else begin
              sbit = b;
            end
            tmp  = PATTERN >> (int'(PAT_W) - 1 - j);
            pbit = tmp[0];
            if (sbit != pbit) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          res = SW'(n);
        end
      end
    end
    return res;
  endfunction

  // Elaboration-time transition table, indexed by [state][sampled bit].
  logic [SW-1:0] trans [PAT_W+1][2];

  for (genvar gk = 0; gk <= PAT_W; gk++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      assign trans[gk][gb] = next_of(gk, 1'(gb));
    end
  end

  state_e state_q;
  state_e state_d;
  logic   enter_det;

  always_comb begin
    state_d = StS0;
    if (state_q > StDetect) begin
      // Unused encodings recover to S0.
      state_d = StS0;
    end else if (!en) begin
      state_d = state_q;
    end else if ((state_q == StDetect) && !OVERLAP) begin
      state_d = state_e'(trans[0][inp]);
    end else begin
      state_d = state_e'(trans[state_q][inp]);
    end
  end

  // Counts DETECT -> DETECT too, but never a held DETECT while en=0.
  assign enter_det = en && (state_d == StDetect);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StS0;
      out         <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      state_q <= state_d;
      out     <= (state_d == StDetect);
      if (clr_cnt) begin
        // Clear wins over a simultaneous DETECT entry.
        match_count <= '0;
        count_sat   <= 1'b0;
      end else if (enter_det) begin
        if (match_count != CntMax) begin
          match_count <= match_count + CNT_W'(1);
        end
        if ((match_count == CntPre) || (match_count == CntMax)) begin
          count_sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_moore_param.sv
module tb_seq_detector_moore_param;

  logic clk;
  logic rst;
  logic inp;
  logic en;
  logic clr_cnt;

  // Three configurations share one input stream.
  logic       out0, out1, out2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic       sat0, sat1, sat2;

  seq_detector_moore_param #(
    .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)
  ) u_ovl (
    .clk(clk), .rst(rst), .inp(inp), .en(en), .clr_cnt(clr_cnt),
    .out(out0), .match_count(cnt0), .count_sat(sat0)
  );

  seq_detector_moore_param #(
    .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)
  ) u_novl (
    .clk(clk), .rst(rst), .inp(inp), .en(en), .clr_cnt(clr_cnt),
    .out(out1), .match_count(cnt1), .count_sat(sat1)
  );

  seq_detector_moore_param #(
    .PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)
  ) u_sat (
    .clk(clk), .rst(rst), .inp(inp), .en(en), .clr_cnt(clr_cnt),
    .out(out2), .match_count(cnt2), .count_sat(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model: a detect happens when the last PAT_W sampled bits equal
  // the pattern and at least PAT_W bits were sampled since reset (or, without
  // overlap, since the previous detect).
  int pw   [3] = '{4, 4, 2};
  int pat  [3] = '{11, 11, 3};
  bit ovl  [3] = '{1'b1, 1'b0, 1'b1};
  int cmax [3] = '{255, 255, 3};

  int m_hist [3];
  int m_nv   [3];
  bit m_out  [3];
  int m_cnt  [3];
  bit m_sat  [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int h;
      int nv;
      int c;
      bit s;
      bit o;
      bit det;
      h   = m_hist[i];
      nv  = m_nv[i];
      c   = m_cnt[i];
      s   = m_sat[i];
      o   = m_out[i];
      det = 1'b0;
      if (!rst) begin
        h = 0; nv = 0; c = 0; s = 1'b0; o = 1'b0;
      end else begin
        if (en) begin
          h   = ((h << 1) | int'(inp)) & 32'hffff;
          nv  = nv + 1;
          det = (nv >= pw[i]) && ((h & ((1 << pw[i]) - 1)) == pat[i]);
          if (det && !ovl[i]) nv = 0;
          if (nv > 64) nv = 64;
          o = det;
        end
        if (clr_cnt) begin
          c = 0; s = 1'b0;
        end else if (det) begin
          if (c < cmax[i]) c = c + 1;
          if (c == cmax[i]) s = 1'b1;
        end
      end
      m_hist[i] <= h;
      m_nv[i]   <= nv;
      m_cnt[i]  <= c;
      m_sat[i]  <= s;
      m_out[i]  <= o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ovl_out", 32'(out0), 32'(m_out[0]));
      chk("ovl_cnt", 32'(cnt0), m_cnt[0]);
      chk("ovl_sat", 32'(sat0), 32'(m_sat[0]));
      chk("novl_out", 32'(out1), 32'(m_out[1]));
      chk("novl_cnt", 32'(cnt1), m_cnt[1]);
      chk("novl_sat", 32'(sat1), 32'(m_sat[1]));
      chk("sat_out", 32'(out2), 32'(m_out[2]));
      chk("sat_cnt", 32'(cnt2), m_cnt[2]);
      chk("sat_sat", 32'(sat2), 32'(m_sat[2]));
    end
  end

  task automatic step(input logic r, input logic b, input logic e, input logic c);
    rst = r; inp = b; en = e; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    step(1'b1, b, 1'b1, 1'b0);
  endtask

  logic [11:0] s_ovl;
  logic [6:0]  s_nov;

  initial begin
    rst = 1'b0; inp = 1'b0; en = 1'b1; clr_cnt = 1'b0;

    // Reset held 3 cycles with toggling input.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'(i % 2 == 0), 1'b1, 1'b0);
      chk_on = 1'b1;
      chk("rst_out", 32'(out0), 0);
      chk("rst_cnt", 32'(cnt0), 0);
      chk("rst_sat", 32'(sat0), 0);
    end
    send(1'b1); send(1'b0); send(1'b1);
    chk("post_rst_3bits", 32'(out0), 0);
    send(1'b1);
    chk("post_rst_4bits", 32'(out0), 1);

    // Overlapping stream: pulses after bits 5, 9, 12.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    s_ovl = 12'b010111011011;
    for (int i = 0; i < 12; i++) begin
      send(s_ovl[11 - i]);
      chk($sformatf("ovl_stream_out%0d", i + 1), 32'(out0),
          32'((i == 4) || (i == 8) || (i == 11)));
    end
    chk("ovl_stream_cnt", 32'(cnt0), 3);

    // Non-overlap vs overlap on 1011011.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    s_nov = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      send(s_nov[6 - i]);
      chk($sformatf("novl_out%0d", i + 1), 32'(out1), 32'(i == 3));
      chk($sformatf("ovl2_out%0d", i + 1), 32'(out0), 32'((i == 3) || (i == 6)));
    end
    chk("novl_cnt", 32'(cnt1), 1);
    chk("ovl2_cnt", 32'(cnt0), 2);

    // Enable gating in the middle and right after DETECT.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b1); send(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 1'b0, 1'b0);
    send(1'b1);
    chk("en_gap_pre", 32'(out0), 0);
    send(1'b1);
    chk("en_gap_det", 32'(out0), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'(i % 2), 1'b0, 1'b0);
      chk("en_hold_out", 32'(out0), 1);
    end
    chk("en_hold_cnt", 32'(cnt0), 1);

    // Saturation of the 2-bit counter, then clear against a detect edge.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(1'b1);
      chk($sformatf("sat_cnt%0d", i + 1), 32'(cnt2), (i == 0) ? 0 : ((i >= 3) ? 3 : i));
      chk($sformatf("sat_flag%0d", i + 1), 32'(sat2), 32'(i >= 3));
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt_val", 32'(cnt2), 0);
    chk("clr_sat_val", 32'(sat2), 0);
    chk("clr_out_kept", 32'(out2), 1);

    // Reset in the middle of a partial match.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b1); send(1'b0); send(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send(1'b1);
    chk("midrst_nodet", 32'(out0), 0);
    send(1'b0); send(1'b1); send(1'b1);
    chk("midrst_det", 32'(out0), 1);

    // Randomised traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
